// File: rtl/onehot_event_encoder_pkg.sv
// Shared types and constants for the one-hot event encoder.
// Mode constants and a one-hot to binary helper.
package enc_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = $clog2(N_DEF);

    localparam bit ARB_FIXED = 1'b0;
    localparam bit ARB_RR    = 1'b1;

    function automatic logic [W_DEF-1:0] onehot_to_bin(
        input logic [N_DEF-1:0] oh
    );
        logic [W_DEF-1:0] b;
        b = '0;
        for (int i = 0; i < N_DEF; i++) begin
            if (oh[i]) b = b | W_DEF'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/onehot_event_encoder_if.sv
// Request lines, code stream handshake and status of the encoder.
// master = encoder side, slave = source/consumer side.
interface onehot_event_encoder_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) ();
    logic [N-1:0] req;
    logic [W-1:0] code;
    logic         valid;
    logic         ready;
    logic [N-1:0] pending;
    logic         overrun;
    logic         busy;

    modport master (
        input  req, ready,
        output code, valid, pending, overrun, busy
    );

    modport slave (
        output req, ready,
        input  code, valid, pending, overrun, busy
    );
endinterface

// File: rtl/onehot_event_encoder_arb.sv
// Combinational arbiter: round-robin after a pointer, or
// fixed priority with the highest index winning.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] pend_i,
    input  logic [W-1:0] ptr_i,
    input  logic         rr_i,
    output logic [W-1:0] grant_o,
    output logic         any_o
);
    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        grant_o = '0;
        any_o   = |pend_i;
        idx     = '0;
        found   = 1'b0;
        if (rr_i) begin
            // search starts just after the last winner and wraps
            for (int k = 1; k <= N; k++) begin
                idx = W'((int'(ptr_i) + k) % N);
                if (!found && pend_i[idx]) begin
                    grant_o = idx;
                    found   = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pend_i[i]) grant_o = W'(i);
            end
        end
    end
endmodule

// File: rtl/onehot_event_encoder.sv
// Latches one-hot events as pending and streams their binary
// indices one at a time over a valid/ready port.
module onehot_event_encoder
    import enc_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = $clog2(N),
    parameter bit RR = ARB_RR
) (
    input  logic                   clk,
    input  logic                   rst,
    onehot_event_encoder_if.master bus
);
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] code_q, code_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         valid_q, valid_d;
    logic         ovr_q, ovr_d;
    logic [W-1:0] grant;
    logic         any;
    logic         load;
    logic         take;

    rr_arbiter #(.N(N), .W(W)) u_arb (
        .pend_i  (pend_q),
        .ptr_i   (ptr_q),
        .rr_i    (RR),
        .grant_o (grant),
        .any_o   (any)
    );

    assign load = !valid_q || bus.ready;
    assign take = load && any;

    always_comb begin
        pend_d  = '0;
        ovr_d   = 1'b0;
        code_d  = code_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        // a request on the line being granted re-arms it cleanly
        for (int i = 0; i < N; i++) begin
            pend_d[i] = (pend_q[i] && !(take && grant == W'(i)))
                      || bus.req[i];
            if (bus.req[i] && pend_q[i]
                && !(take && grant == W'(i)))
                ovr_d = 1'b1;
        end
        if (load) begin
            valid_d = any;
            if (any) begin
                code_d = grant;
                if (RR) ptr_d = grant;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ptr_q   <= W'(N - 1);
        end else begin
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pend_q;
    assign bus.overrun = ovr_q;
    assign bus.busy    = |pend_q || valid_q;
endmodule

// File: doc/onehot_event_encoder.md
Name: onehot_event_encoder

Overview:
- Encoder-side counterpart of the team's 3-to-8 decoder: turns events on N one-hot request lines into a stream of binary index codes (8 lines -> 3-bit code).
- Each request is latched as pending, arbitrated, and presented one code at a time on a valid/ready output port.
- Sits between raw event sources (buttons, sensor strobes, mux selects) and any consumer that expects a binary select, e.g. a downstream decoder.

Parameters:
- N, 8, number of request lines (2..32).
- W, $clog2(N), code width (3 for N=8).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (highest index wins).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  event request lines, sampled every clk edge; bit i set means event on line i.
- code  out  W  binary index of the granted line; registered.
- valid  out  1  code holds a valid index.
- ready  in  1  consumer accepts code this cycle when valid && ready.
- pending  out  N  registered pending-event vector (visibility/debug).
- overrun  out  1  one-cycle registered pulse: an event was lost.
- busy  out  1  combinational: |pending || valid.

Behaviour:
- Reset (rst=1 at edge): pending=0, code=0, valid=0, overrun=0, rr_ptr=N-1. Reset takes priority over all other activity. It discards any pending events and any held code mid-transfer.
- Load condition: load = !valid || ready. On an edge where load=1 and pending!=0:
  - the grant index g is selected from pending;
  - code<=g and valid<=1;
  - pending[g] is cleared;
  - in RR mode, rr_ptr<=g.
- If load=1 and pending==0, then valid<=0 and code holds its last value.
- If valid && !ready, code and valid hold; code must not change while valid=1 and ready=0.
- Pending update per bit i: pending[i] <= (pending[i] && !(load && g==i)) || req[i].
  - req[i] in the same cycle that line i is granted re-arms pending[i] as a new event; this is not an overrun.
- Overrun: overrun<=1 on the next edge if any i has req[i]=1 and pending[i]=1, and line i is not granted that cycle. Otherwise overrun<=0. A held req level therefore signals overrun each cycle until it is granted.
- Grant selection, RR=1: search pending starting at (rr_ptr+1) mod N, wrapping, and take the first set bit. After reset the first search starts at index 0.
- Grant selection, RR=0: highest set index wins. rr_ptr is unused.
- Latency:
  - req sampled at edge k -> pending at edge k.
  - code/valid at edge k+1 if the output stage is free, i.e. 1 cycle from sample to valid.
- Throughput: one code per cycle while ready=1 and pending!=0.
- Width: g is zero-extended to W bits. For N not a power of two, codes >= N are never produced.
- Simultaneous events: all bits of a multi-hot req are latched in the same cycle and drained in arbitration order over successive cycles. None are lost.

Decomposition:
- Shared package enc_pkg: parameter defaults for N and W, RR mode constants ARB_FIXED=0 and ARB_RR=1, and a function onehot_to_bin for reuse by testbenches.
- One natural sub-module: rr_arbiter (pending vector + pointer + mode -> grant index and any-grant). It is purely combinational.
- The top level holds the pending, output and overrun registers.

Test Plan:
1. Reset, then a single pulse req=8'b0000_0100 for one cycle, ready=1 -> next edge code=3'd2 and valid=1. The edge after that gives valid=0, pending=0, busy=0.
2. RR=1, req=8'b1010_0001 for one cycle, ready=1 -> codes 0, 5, 7 on consecutive cycles, then valid=0. With RR=0 the same stimulus gives 7, 5, 0.
3. Backpressure: req=8'b0001_0010, ready=0 for 4 cycles -> code=1 and valid=1 hold stable and pending=8'b0001_0000. After ready=1, code 4 follows, then valid=0.
4. Overrun: req[3] pulsed on two consecutive cycles while ready=0 and code 3 is already held -> overrun pulses for 1 cycle and pending[3]=1. Only two code-3 transfers complete after ready rises.
5. Re-arm without overrun: req[6] asserted on the exact edge line 6 is granted -> pending[6]=1 after the edge, overrun=0, and a second code 6 appears.
6. Reset mid-operation: pending=8'hFF with code valid, then rst=1 for one edge -> pending=0, valid=0, code=0, overrun=0. The next req=8'h80 yields code 7 (RR search starts at 0).
